// File: rtl/force_release_ctrl.sv
// force_release_ctrl
// ------------------
// Command-driven override engine for a bank of NCH driven signals, each W
// bits wide. A channel can be forced to a value, either indefinitely or for a
// fixed number of cycles. When it is released it either returns to its
// functional driver at once (net-style) or keeps the forced value until the
// driver next changes (variable-style, "hold").
//
// Ports
//   clk        clock; all state updates on posedge
//   rst        asynchronous reset, active-high
//   cmd_valid  command present
//   cmd_ready  controller can take a command (low while a RELEASE_ALL sweeps)
//   cmd_op     00 NOP, 01 FORCE, 10 RELEASE, 11 RELEASE_ALL
//   cmd_ch     target channel (ignored for RELEASE_ALL)
//   cmd_value  force value
//   cmd_dur    forced cycles before auto-release; 0 = indefinite
//   cmd_hold   1 = variable-style release, 0 = net-style release
//   drv_in     functional driver values, channel i at [i*W +: W]
//   ovr_out    values seen by consumers, channel i at [i*W +: W]
//   forced     channel i currently forced
//   rel_pulse  one-cycle registered pulse after channel i leaves FORCED
//   err        sticky; an accepted command named a channel >= NCH
//
// Handshake: a command transfers on a posedge where cmd_valid && cmd_ready.
// The command fields only need to be stable on that edge. The controller
// never retracts cmd_ready while cmd_valid is waiting, except when it enters
// a sweep. A sweep only starts on an accepted RELEASE_ALL, so a command that
// is already waiting cannot be the one that gets blocked.
module force_release_ctrl #(
  parameter int NCH   = 4,
  parameter int W     = 32,
  parameter int DUR_W = 8,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CH_W-1:0]      cmd_ch,
  input  logic [W-1:0]         cmd_value,
  input  logic [DUR_W-1:0]     cmd_dur,
  input  logic                 cmd_hold,
  input  logic [NCH*W-1:0]     drv_in,
  output logic [NCH*W-1:0]     ovr_out,
  output logic [NCH-1:0]       forced,
  output logic [NCH-1:0]       rel_pulse,
  output logic                 err
);

  // Opcode 00 (NOP) needs no decode: it is accepted and nothing reacts to it.
  localparam logic [1:0] OP_FORCE       = 2'b01;
  localparam logic [1:0] OP_RELEASE     = 2'b10;
  localparam logic [1:0] OP_RELEASE_ALL = 2'b11;

  typedef enum logic [1:0] {
    CH_FREE   = 2'd0,
    CH_FORCED = 2'd1,
    CH_HELD   = 2'd2
  } ch_state_e;

  typedef enum logic {
    CTL_IDLE  = 1'b0,
    CTL_SWEEP = 1'b1
  } ctl_state_e;

  // Per-channel state
  ch_state_e        st_q   [NCH];
  ch_state_e        st_d   [NCH];
  logic [W-1:0]     fval_q [NCH];
  logic [W-1:0]     fval_d [NCH];
  logic [W-1:0]     hdrv_q [NCH];
  logic [W-1:0]     hdrv_d [NCH];
  logic [DUR_W-1:0] cnt_q  [NCH];
  logic [DUR_W-1:0] cnt_d  [NCH];
  logic [NCH-1:0]   hold_q;
  logic [NCH-1:0]   hold_d;
  logic [NCH-1:0]   rel_now;   // channel leaves FORCED on this edge
  logic [NCH-1:0]   rel_tgt;   // 1 = leave into HELD, 0 = into FREE
  logic [NCH-1:0]   rel_pulse_q;

  // Controller state
  ctl_state_e       ctl_q;
  ctl_state_e       ctl_d;
  logic [CH_W-1:0]  idx_q;
  logic [CH_W-1:0]  idx_d;
  logic             sweep_hold_q;
  logic             sweep_hold_d;
  logic             err_q;
  logic             err_d;

  logic             accept;
  logic             ch_ok;

  assign cmd_ready = (ctl_q == CTL_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  // The channel field can hold values past NCH-1 when NCH is not a power of 2.
  assign ch_ok     = (32'(cmd_ch) < NCH);

  // ------------------------------------------------------------------------
  // Controller: IDLE takes commands. SWEEP walks idx from 0 to NCH-1, one
  // channel per edge, and takes no commands while it does so.
  // ------------------------------------------------------------------------
  always_comb begin
    ctl_d        = ctl_q;
    idx_d        = idx_q;
    sweep_hold_d = sweep_hold_q;
    err_d        = err_q;

    case (ctl_q)
      CTL_IDLE: begin
        if (accept && cmd_op == OP_RELEASE_ALL) begin
          ctl_d        = CTL_SWEEP;
          idx_d        = '0;
          sweep_hold_d = cmd_hold;
        end
      end
      CTL_SWEEP: begin
        if (idx_q == CH_W'(NCH - 1)) begin
          ctl_d = CTL_IDLE;
          idx_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ctl_d = CTL_IDLE;
    endcase

    // RELEASE_ALL ignores cmd_ch, so it cannot raise err.
    if (accept && cmd_op != OP_RELEASE_ALL && !ch_ok) begin
      err_d = 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Channel next-state. Priority, lowest first:
  //   auto-expiry and hold-break, then the sweep, then an explicit command.
  // A FORCE on the expiry edge cancels the release, so no pulse is raised.
  // ------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      st_d[i]   = st_q[i];
      fval_d[i] = fval_q[i];
      hdrv_d[i] = hdrv_q[i];
      cnt_d[i]  = cnt_q[i];
      hold_d[i] = hold_q[i];
      rel_now[i] = 1'b0;
      rel_tgt[i] = 1'b0;

      case (st_q[i])
        CH_FORCED: begin
          if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
            // The 1->0 edge ends the force: exactly cmd_dur forced cycles.
            if (cnt_q[i] == DUR_W'(1)) begin
              rel_now[i] = 1'b1;
              rel_tgt[i] = hold_q[i];
            end
          end
        end
        CH_HELD: begin
          if (drv_in[i*W +: W] != hdrv_q[i]) begin
            st_d[i] = CH_FREE;
          end
        end
        default: ;
      endcase

      if (ctl_q == CTL_SWEEP && idx_q == CH_W'(i) && st_q[i] == CH_FORCED) begin
        rel_now[i] = 1'b1;
        rel_tgt[i] = sweep_hold_q;
      end

      if (accept && ch_ok && cmd_ch == CH_W'(i)) begin
        if (cmd_op == OP_FORCE) begin
          st_d[i]    = CH_FORCED;
          fval_d[i]  = cmd_value;
          cnt_d[i]   = cmd_dur;
          hold_d[i]  = cmd_hold;
          rel_now[i] = 1'b0;
        end else if (cmd_op == OP_RELEASE && st_q[i] == CH_FORCED) begin
          rel_now[i] = 1'b1;
          rel_tgt[i] = cmd_hold;
        end
      end

      if (rel_now[i]) begin
        if (rel_tgt[i]) begin
          st_d[i]   = CH_HELD;
          // A held channel stays held until the driver moves off this value.
          hdrv_d[i] = drv_in[i*W +: W];
        end else begin
          st_d[i] = CH_FREE;
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]   <= CH_FREE;
        fval_q[i] <= '0;
        hdrv_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      hold_q       <= '0;
      rel_pulse_q  <= '0;
      ctl_q        <= CTL_IDLE;
      idx_q        <= '0;
      sweep_hold_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i]   <= st_d[i];
        fval_q[i] <= fval_d[i];
        hdrv_q[i] <= hdrv_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      hold_q       <= hold_d;
      rel_pulse_q  <= rel_now;
      ctl_q        <= ctl_d;
      idx_q        <= idx_d;
      sweep_hold_q <= sweep_hold_d;
      err_q        <= err_d;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs. A FREE channel passes its driver through combinationally, and
  // this includes the time while rst is high.
  // ------------------------------------------------------------------------
  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign ovr_out[g*W +: W] = (st_q[g] == CH_FREE) ? drv_in[g*W +: W] : fval_q[g];
    assign forced[g]         = (st_q[g] == CH_FORCED);
  end

  assign rel_pulse = rel_pulse_q;
  assign err       = err_q;

endmodule
